// File: rtl/ahb_seq_pkg.sv
// Shared types and constants for the AHB request sequencer: bus encodings,
// FSM states, the queued command layout and the burst-to-beat decode.
package ahb_seq_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_START,
    ST_WAIT_END,
    ST_DRAIN,
    ST_GAP
  } seq_state_e;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [2:0]  bsize;
  } seq_cmd_t;

  // Undefined-length INCR is issued as a single beat by this sequencer.
  function automatic logic [4:0] beats_of(input logic [2:0] bsize);
    case (bsize[2:1])
      2'b00:   return 5'd1;
      2'b01:   return 5'd4;
      2'b10:   return 5'd8;
      default: return 5'd16;
    endcase
  endfunction

endpackage

// File: rtl/seq_cmd_fifo.sv
// Synchronous command FIFO; the head entry is visible without popping so the
// sequencer can hold it for the whole life of a transfer.
module seq_cmd_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 4
) (
  input  logic                     hclk,
  input  logic                     hresetn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic [WIDTH-1:0]         head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_level == (AW+1)'(DEPTH));
  assign empty  = (r_level == '0);
  assign level  = r_level;
  assign head   = r_mem[r_rd_ptr];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // NOTE: storage is deliberately left out of reset; an entry is only ever
  // read once r_level says it was written, so reset values would be dead logic.
  always_ff @(posedge hclk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/ahb_req_seq.sv
// Command sequencer in front of one AHB master: issues queued read/write
// requests, counts the master's beats and retires each command or times it out.
module ahb_req_seq
  import ahb_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TMO_W = 10
) (
  input  logic                   hclk,
  input  logic                   hresetn,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [31:0]            cmd_addr,
  input  logic [2:0]             cmd_bsize,
  output logic                   mst_wr_req,
  output logic                   mst_rd_req,
  output logic [31:0]            src_addr,
  output logic [2:0]             block_size,
  input  logic                   hgrant,
  input  logic                   hready,
  input  logic [1:0]             htrans,
  output logic                   busy,
  output logic                   done,
  output logic                   tmo_err,
  output logic [$clog2(DEPTH):0] level
);

  localparam int LW = $clog2(DEPTH) + 1;
  // The counter is compared one short of all-ones so that the error lands on
  // the same edge the count would reach all-ones.
  localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  seq_state_e       r_state;
  logic             r_wr_req;
  logic             r_rd_req;
  logic [31:0]      r_src_addr;
  logic [2:0]       r_block_size;
  logic             r_done;
  logic             r_tmo_err;
  logic             r_busy;
  logic [TMO_W-1:0] r_tmo;
  logic [4:0]       r_beat_cnt;
  logic [4:0]       r_exp;

  seq_cmd_t         w_head;
  seq_cmd_t         w_cmd_in;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_beat;
  logic             w_progress;
  logic             w_waiting;
  logic             w_tmo_fire;
  logic             w_next_idle;
  logic [LW-1:0]    w_level_nxt;

  assign w_cmd_in  = '{write: cmd_write, addr: cmd_addr, bsize: cmd_bsize};
  assign cmd_ready = !w_full;
  assign w_push    = cmd_valid && !w_full;

  seq_cmd_fifo #(
    .WIDTH ($bits(seq_cmd_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .hclk    (hclk),
    .hresetn (hresetn),
    .push    (w_push),
    .pop     (w_pop),
    .din     (w_cmd_in),
    .full    (w_full),
    .empty   (w_empty),
    .level   (level),
    .head    (w_head)
  );

  // IDLE and BUSY transfers, stalled cycles and ungranted cycles never count.
  assign w_beat = hgrant && hready &&
                  (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);

  assign w_progress = (r_state == ST_WAIT_START) ? (w_beat && htrans == HTRANS_NONSEQ) :
                      (r_state == ST_WAIT_END)   ? w_beat :
                      (r_state == ST_DRAIN)      ? hready : 1'b0;
  assign w_waiting  = (r_state == ST_WAIT_START) || (r_state == ST_WAIT_END) ||
                      (r_state == ST_DRAIN);
  assign w_tmo_fire = w_waiting && !w_progress && (r_tmo == TMO_LAST);

  assign w_pop       = ((r_state == ST_DRAIN) && hready) || w_tmo_fire;
  assign w_level_nxt = level + LW'(w_push) - LW'(w_pop);
  assign w_next_idle = (r_state == ST_GAP) || ((r_state == ST_IDLE) && w_empty);

  // NOTE: every state register below uses <= so all updates see the values
  // from before the edge; a blocking = here would chain same-cycle updates.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_state      <= ST_IDLE;
      r_wr_req     <= 1'b0;
      r_rd_req     <= 1'b0;
      r_src_addr   <= '0;
      r_block_size <= '0;
      r_done       <= 1'b0;
      r_tmo_err    <= 1'b0;
      r_busy       <= 1'b0;
      r_tmo        <= '0;
      r_beat_cnt   <= '0;
      r_exp        <= '0;
    end else begin
      r_done <= 1'b0;
      r_busy <= !w_next_idle || (w_level_nxt != '0);
      if (w_tmo_fire) begin
        r_tmo_err <= 1'b1;
        r_wr_req  <= 1'b0;
        r_rd_req  <= 1'b0;
        r_state   <= ST_GAP;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (!w_empty) r_state <= ST_ISSUE;
          end
          ST_ISSUE: begin
            r_wr_req     <= w_head.write;
            r_rd_req     <= !w_head.write;
            r_src_addr   <= w_head.addr;
            r_block_size <= w_head.bsize;
            r_exp        <= beats_of(w_head.bsize);
            r_beat_cnt   <= '0;
            r_tmo        <= '0;
            r_state      <= ST_WAIT_START;
          end
          ST_WAIT_START: begin
            if (w_progress) begin
              r_wr_req   <= 1'b0;
              r_rd_req   <= 1'b0;
              r_beat_cnt <= 5'd1;
              r_tmo      <= '0;
              r_state    <= (r_exp == 5'd1) ? ST_DRAIN : ST_WAIT_END;
            end else begin
              r_tmo <= r_tmo + TMO_W'(1);
            end
          end
          ST_WAIT_END: begin
            if (w_progress) begin
              r_beat_cnt <= r_beat_cnt + 5'd1;
              r_tmo      <= '0;
              if (r_beat_cnt + 5'd1 == r_exp) r_state <= ST_DRAIN;
            end else begin
              r_tmo <= r_tmo + TMO_W'(1);
            end
          end
          ST_DRAIN: begin
            if (w_progress) begin
              r_done  <= 1'b1;
              r_state <= ST_GAP;
            end else begin
              r_tmo <= r_tmo + TMO_W'(1);
            end
          end
          ST_GAP: begin
            r_wr_req     <= 1'b0;
            r_rd_req     <= 1'b0;
            r_src_addr   <= '0;
            r_block_size <= '0;
            r_state      <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign mst_wr_req = r_wr_req;
  assign mst_rd_req = r_rd_req;
  assign src_addr   = r_src_addr;
  assign block_size = r_block_size;
  assign done       = r_done;
  assign tmo_err    = r_tmo_err;
  assign busy       = r_busy;

endmodule

// File: tb/tb_ahb_req_seq.sv
// Scoreboard bench for ahb_req_seq: commands are queued with their expected
// outcome and retired when the sequencer reports done or a timeout.
module tb_ahb_req_seq;

  localparam int DEPTH = 4;
  localparam int TMO_W = 4;
  localparam int P_NORM  = 0;
  localparam int P_STALL = 1;
  localparam int P_TMO   = 2;
  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NONSEQ = 2'b10, T_SEQ = 2'b11;

  logic        hclk = 1'b0;
  logic        hresetn = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [2:0]  cmd_bsize = '0;
  logic        mst_wr_req, mst_rd_req;
  logic [31:0] src_addr;
  logic [2:0]  block_size;
  logic        hgrant = 1'b0;
  logic        hready = 1'b1;
  logic [1:0]  htrans = 2'b00;
  logic        busy, done, tmo_err;
  logic [2:0]  level;

  ahb_req_seq #(.DEPTH(DEPTH), .TMO_W(TMO_W)) dut (
    .hclk(hclk), .hresetn(hresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_bsize(cmd_bsize),
    .mst_wr_req(mst_wr_req), .mst_rd_req(mst_rd_req),
    .src_addr(src_addr), .block_size(block_size),
    .hgrant(hgrant), .hready(hready), .htrans(htrans),
    .busy(busy), .done(done), .tmo_err(tmo_err), .level(level)
  );

  always #5 hclk = ~hclk;

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [2:0]  bs;
    bit          tmo;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int n_checks = 0, n_errors = 0;
  int cyc = 0, last_done_cyc = 0, n_done = 0, model_level = 0;
  logic prev_req = 1'b0, prev_tmo = 1'b0, cap_w = 1'b0;
  logic [31:0] cap_a = '0;
  logic [2:0]  cap_bs = '0;

  always @(posedge hclk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int exp_beats(input logic [2:0] bs);
    case (bs)
      3'b000, 3'b001: return 1;
      3'b010, 3'b011: return 4;
      3'b100, 3'b101: return 8;
      default:        return 16;
    endcase
  endfunction

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  // Retire scoreboard entries on done pulses and on the rising edge of tmo_err.
  always @(negedge hclk) begin
    if (!hresetn) begin
      prev_req = 1'b0;
      prev_tmo = 1'b0;
    end else begin
      if (mst_wr_req || mst_rd_req) check("req_excl", mst_wr_req & mst_rd_req, 0);
      if ((mst_wr_req || mst_rd_req) && !prev_req) begin
        cap_w  = mst_wr_req;
        cap_a  = src_addr;
        cap_bs = block_size;
      end
      if (done || (tmo_err && !prev_tmo)) begin
        check("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          check("ev_is_tmo", done ? 0 : 1, mon_e.tmo);
          check("cap_write", cap_w, mon_e.w);
          check("cap_addr", cap_a, mon_e.a);
          check("cap_bsize", cap_bs, mon_e.bs);
        end
        model_level--;
        if (done) begin
          n_done++;
          last_done_cyc = cyc;
        end
      end
      prev_req = mst_wr_req || mst_rd_req;
      prev_tmo = tmo_err;
    end
  end

  task automatic push(input logic w, input logic [31:0] a, input logic [2:0] bs,
                      input int plan, output int push_cyc);
    bit exp_rdy;
    exp_rdy   = (model_level < DEPTH);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_bsize = bs;
    check("cmd_ready", cmd_ready, exp_rdy);
    if (exp_rdy) begin
      sb.push_back('{w: w, a: a, bs: bs, tmo: (plan == P_TMO)});
      model_level++;
    end
    tick();
    cmd_valid = 1'b0;
    push_cyc  = cyc;
    check("level_push", level, model_level);
  endtask

  task automatic serve(input int plan, input logic [31:0] addr, input logic [2:0] bs,
                       input bit chk_gap, output int req_cyc);
    int n, k;
    bit got;
    n = exp_beats(bs);
    got = 1'b0;
    req_cyc = 0;
    for (int i = 0; i < 30; i++) begin
      if (mst_wr_req || mst_rd_req) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    check("req_seen", got, 1);
    if (!got) return;
    req_cyc = cyc;
    if (chk_gap) check("req_gap", cyc - last_done_cyc, 3);
    check("src_addr", src_addr, addr);
    check("block_size", block_size, bs);
    hgrant = 1'b0;
    if (plan == P_TMO) begin
      k = 0;
      while (!tmo_err && k < 40) begin
        tick();
        k++;
      end
      check("tmo_cycles", k, 15);
      check("tmo_req_low", mst_wr_req | mst_rd_req, 0);
      check("tmo_no_done", done, 0);
      return;
    end
    tick();
    check("req_hold", mst_wr_req | mst_rd_req, 1);
    for (int i = 0; i < n; i++) begin
      if (plan == P_STALL && i == 3) begin
        hgrant = 1'b1; htrans = T_SEQ; hready = 1'b0;
        tick();
        tick();
        hready = 1'b1; htrans = T_BUSY;
        tick();
        check("stall_no_done", done, 0);
      end
      hgrant = 1'b1; hready = 1'b1;
      htrans = (i == 0) ? T_NONSEQ : T_SEQ;
      tick();
      if (i == 0) check("req_drop", mst_wr_req | mst_rd_req, 0);
      check("src_hold", src_addr, addr);
      check("no_early_done", done, 0);
    end
    htrans = T_IDLE; hready = 1'b0;
    tick();
    check("drain_wait", done, 0);
    hready = 1'b1;
    tick();
    check("done", done, 1);
    check("src_at_done", src_addr, addr);
    check("bsize_at_done", block_size, bs);
    hgrant = 1'b0;
    tick();
    check("done_pulse", done, 0);
    check("src_idle", src_addr, 0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int pc, rc;
    logic [31:0] fa [5];
    logic [2:0]  fbs [5];
    logic        fw [5];

    #1 hresetn = 1'b0;
    tick();
    tick();
    check("rst_level", level, 0);
    check("rst_ready", cmd_ready, 1);
    check("rst_outs", {mst_wr_req, mst_rd_req, busy, done, tmo_err}, 0);
    check("rst_addr", {src_addr, 1'b0, block_size}, 0);
    hresetn = 1'b1;
    tick();

    // Single write: latency and one done.
    push(1'b1, 32'h0, 3'b000, P_NORM, pc);
    check("busy_after_push", busy, 1);
    serve(P_NORM, 32'h0, 3'b000, 1'b0, rc);
    check("first_req_latency", rc - pc, 2);
    check("level_single", level, 0);
    check("busy_idle", busy, 0);
    check("done_cnt1", n_done, 1);

    // INCR4 write at 0.
    push(1'b1, 32'h0, 3'b011, P_NORM, pc);
    serve(P_NORM, 32'h0, 3'b011, 1'b0, rc);
    check("done_cnt2", n_done, 2);

    // Fill the FIFO while the master is still idle; fifth push is refused.
    for (int i = 0; i < 5; i++) begin
      fa[i]  = 32'h1000 + 32'(i) * 32'h40;
      fw[i]  = i[0];
      fbs[i] = 3'(2 * i);
    end
    for (int i = 0; i < 5; i++) push(fw[i], fa[i], fbs[i], P_NORM, pc);
    check("fill_level", level, 4);
    check("fill_ready", cmd_ready, 0);
    for (int i = 0; i < 4; i++) serve(P_NORM, fa[i], fbs[i], i > 0, rc);
    check("done_cnt_fill", n_done, 6);
    check("fill_drained", level, 0);
    check("sb_empty_fill", sb.size(), 0);

    // INCR8 read with wait states and a BUSY transfer.
    push(1'b0, 32'h2000, 3'b101, P_NORM, pc);
    serve(P_STALL, 32'h2000, 3'b101, 1'b0, rc);
    check("done_cnt_stall", n_done, 7);

    // Timeout on an ungranted command, then the next one runs.
    push(1'b1, 32'h3000, 3'b010, P_TMO, pc);
    push(1'b0, 32'h3100, 3'b001, P_NORM, pc);
    serve(P_TMO, 32'h3000, 3'b010, 1'b0, rc);
    check("tmo_set", tmo_err, 1);
    serve(P_NORM, 32'h3100, 3'b001, 1'b0, rc);
    check("done_cnt_tmo", n_done, 8);
    check("tmo_sticky", tmo_err, 1);
    check("tmo_level", level, 0);

    // Reset during beat 2 of an INCR4.
    push(1'b1, 32'h100, 3'b011, P_NORM, pc);
    for (int i = 0; i < 10 && !(mst_wr_req || mst_rd_req); i++) tick();
    hgrant = 1'b1; hready = 1'b1; htrans = T_NONSEQ;
    tick();
    htrans = T_SEQ;
    #2 hresetn = 1'b0;
    #1;
    check("arst_outs", {mst_wr_req, mst_rd_req, busy, done, tmo_err}, 0);
    check("arst_addr", {src_addr, 1'b0, block_size}, 0);
    check("arst_level", level, 0);
    check("arst_ready", cmd_ready, 1);
    sb.delete();
    model_level = 0;
    hgrant = 1'b0; htrans = T_IDLE;
    tick();
    hresetn = 1'b1;
    tick();
    push(1'b0, 32'h200, 3'b110, P_NORM, pc);
    serve(P_NORM, 32'h200, 3'b110, 1'b0, rc);
    check("done_cnt_rst", n_done, 9);
    check("tmo_after_rst", tmo_err, 0);
    check("sb_empty_end", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
